wb_arbiter_2m1s: RTL and testbench

Two-master, one-slave Wishbone arbiter placed directly downstream of the CPU's instruction-side and data-side Wishbone bus interfaces. It grants the single shared slave bus to one master at a time, holds the grant for the whole `cyc` tenure, and routes `ack` and read data back to the owner only. A per-tenure watchdog terminates hung accesses with an error pulse so the requesting interface never stalls the pipeline forever.

---
 rtl/wb_arbiter_2m1s.sv | 82 ++++++++
 tb/tb_wb_arbiter_2m1s.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_2m1s.sv
// wb_arbiter_2m1s: two-master/one-slave Wishbone arbiter with per-tenure watchdog.
// Define WB_ARB_RR_EN for round-robin tie-break; otherwise M0 (data side) wins ties.
module wb_arbiter_2m1s #(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  output logic [31:0] m0_data_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  output logic [31:0] m1_data_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_data_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  input  logic [31:0] s_data_i,
  input  logic        s_ack_i
);
  typedef enum logic [1:0] {IDLE, GNT_M0, GNT_M1} state_t;
  state_t state, state_d, pick;
  logic [7:0] wd_cnt, wd_d;
  logic last, last_d, own0, own1, stb_sel, cyc_sel, timeout, arb, tie_m1;
`ifdef WB_ARB_RR_EN
  assign tie_m1 = !last;
`else
  assign tie_m1 = 1'b0;
`endif
  assign own0 = state == GNT_M0;
  assign own1 = state == GNT_M1;
  always_comb begin
    stb_sel   = own0 ? m0_stb_i : own1 ? m1_stb_i : 1'b0;
    cyc_sel   = own0 ? m0_cyc_i : own1 ? m1_cyc_i : 1'b0;
    timeout   = (TIMEOUT_CYCLES != 8'd0) && stb_sel && !s_ack_i && (wd_cnt == TIMEOUT_CYCLES - 8'd1);
    s_addr_o  = own0 ? m0_addr_i : own1 ? m1_addr_i : '0;
    s_data_o  = own0 ? m0_data_i : own1 ? m1_data_i : '0;
    s_we_o    = own0 ? m0_we_i : own1 ? m1_we_i : 1'b0;
    s_sel_o   = own0 ? m0_sel_i : own1 ? m1_sel_i : '0;
    s_stb_o   = stb_sel && !timeout;
    s_cyc_o   = cyc_sel && !timeout;
    m0_ack_o  = own0 && s_ack_i;
    m1_ack_o  = own1 && s_ack_i;
    m0_data_o = own0 ? s_data_i : '0;
    m1_data_o = own1 ? s_data_i : '0;
    m0_err_o  = own0 && timeout;
    m1_err_o  = own1 && timeout;
    // Re-arbitrate from IDLE or when the owner releases cyc, so hand-over has no dead cycle
    arb     = (state == IDLE) || (own0 && !m0_cyc_i) || (own1 && !m1_cyc_i);
    pick    = (m0_cyc_i && m1_cyc_i) ? (tie_m1 ? GNT_M1 : GNT_M0) :
              m0_cyc_i ? GNT_M0 : m1_cyc_i ? GNT_M1 : IDLE;
    state_d = timeout ? IDLE : arb ? pick : state;
    last_d  = (state_d == GNT_M1) ? 1'b1 : (state_d == GNT_M0) ? 1'b0 : last;
    wd_d    = (s_ack_i || state_d != state || state_d == IDLE) ? 8'd0 :
              stb_sel ? wd_cnt + 8'd1 : wd_cnt;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      wd_cnt <= 8'd0;
      last   <= 1'b1;
    end else begin
      state  <= state_d;
      wd_cnt <= wd_d;
      last   <= last_d;
    end
  end
endmodule

// File: tb/tb_wb_arbiter_2m1s.sv
// tb_wb_arbiter_2m1s: directed self-checking bench for the two-master Wishbone arbiter.
module tb_wb_arbiter_2m1s;
  logic clk = 1'b0, rst = 1'b0;
  logic [31:0] m0_addr_i = '0, m0_data_i = '0, m1_addr_i = '0, m1_data_i = '0, s_data_i = '0;
  logic [3:0] m0_sel_i = '0, m1_sel_i = '0;
  logic m0_we_i = 0, m0_stb_i = 0, m0_cyc_i = 0, m1_we_i = 0, m1_stb_i = 0, m1_cyc_i = 0, s_ack_i = 0;
  logic [31:0] m0_data_o, m1_data_o, s_addr_o, s_data_o;
  logic [3:0] s_sel_o;
  logic m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, s_we_o, s_stb_o, s_cyc_o;
  int checks = 0, failures = 0;
  logic [31:0] tie_addr;
  wb_arbiter_2m1s #(.TIMEOUT_CYCLES(8'd4)) dut (
    .clk(clk), .rst(rst),
    .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_data_i(s_data_i), .s_ack_i(s_ack_i)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic req0(input logic on, input logic [31:0] a);
    m0_cyc_i = on; m0_stb_i = on; m0_addr_i = a; m0_sel_i = 4'hf;
  endtask
  task automatic req1(input logic on, input logic [31:0] a);
    m1_cyc_i = on; m1_stb_i = on; m1_addr_i = a; m1_sel_i = 4'hf;
  endtask
  initial begin
    // reset state
    repeat (2) tick;
    check("rst_s_cyc", s_cyc_o, 0);
    check("rst_s_stb", s_stb_o, 0);
    check("rst_m0_err", m0_err_o, 0);
    rst = 1'b1;
    tick;
    // single M1 read, single-cycle ack
    req1(1, 32'h1000);
    #2 check("m1rd_latency_stb", s_stb_o, 0);
    tick;
    s_ack_i = 1; s_data_i = 32'h2400_0001;
    #2 check("m1rd_s_stb", s_stb_o, 1);
    check("m1rd_s_addr", s_addr_o, 32'h1000);
    check("m1rd_ack", m1_ack_o, 1);
    check("m1rd_data", m1_data_o, 32'h2400_0001);
    check("m1rd_m0_ack", m0_ack_o, 0);
    check("m1rd_m0_data", m0_data_o, 0);
    tick;
    req1(0, 0); s_ack_i = 0; s_data_i = 0;
    #2 check("m1rd_ack_done", m1_ack_o, 0);
    tick;
    // simultaneous requests: M0 first, then policy decides
    req0(1, 32'hA0); req1(1, 32'hB0);
    #2 check("tie_idle_stb", s_stb_o, 0);
    tick;
    s_ack_i = 1; s_data_i = 32'h55;
    #2 check("tie1_addr", s_addr_o, 32'hA0);
    check("tie1_m0_ack", m0_ack_o, 1);
    check("tie1_m1_ack", m1_ack_o, 0);
    tick;
    req0(0, 32'hA0); req1(0, 32'hB0); s_ack_i = 0;
    tick;
    req0(1, 32'hA0); req1(1, 32'hB0);
    tick;
`ifdef WB_ARB_RR_EN
    tie_addr = 32'hB0;
`else
    tie_addr = 32'hA0;
`endif
    s_ack_i = 1;
    #2 check("tie2_addr", s_addr_o, tie_addr);
    check("tie2_m1_ack", m1_ack_o, tie_addr == 32'hB0);
    tick;
    req0(0, 0); req1(0, 0); s_ack_i = 0;
    tick;
    // M0 write with M1 waiting
    req0(1, 32'h100); m0_we_i = 1; m0_data_i = 32'hDEAD_BEEF;
    tick;
    req1(1, 32'hB0);
    #2 check("wr_addr", s_addr_o, 32'h100);
    check("wr_data", s_data_o, 32'hDEAD_BEEF);
    check("wr_we", s_we_o, 1);
    check("wr_sel", s_sel_o, 4'hf);
    check("wr_cyc", s_cyc_o, 1);
    tick;
    s_ack_i = 1;
    #2 check("wr_hold_addr", s_addr_o, 32'h100);
    check("wr_m0_ack", m0_ack_o, 1);
    check("wr_m1_ack", m1_ack_o, 0);
    tick;
    req0(0, 32'h100); m0_we_i = 0; s_ack_i = 0;
    #2 check("ho_drop_cyc", s_cyc_o, 0);
    tick;
    s_ack_i = 1;
    #2 check("ho_m1_addr", s_addr_o, 32'hB0);
    check("ho_m1_stb", s_stb_o, 1);
    check("ho_m1_ack", m1_ack_o, 1);
    tick;
    req1(0, 0); s_ack_i = 0;
    tick;
    // watchdog with TIMEOUT_CYCLES=4
    req1(1, 32'hC0);
    tick;
    #2 check("wd_c1_cyc", s_cyc_o, 1);
    tick; tick;
    #2 check("wd_c3_err", m1_err_o, 0);
    tick;
    #2 check("wd_c4_err", m1_err_o, 1);
    check("wd_c4_cyc", s_cyc_o, 0);
    check("wd_c4_stb", s_stb_o, 0);
    check("wd_c4_m0_err", m0_err_o, 0);
    tick;
    req1(0, 0);
    #2 check("wd_idle_cyc", s_cyc_o, 0);
    check("wd_idle_err", m1_err_o, 0);
    tick;
    // flush: owner drops cyc before ack, late ack ignored
    req0(1, 32'hD0);
    tick;
    #2 check("fl_addr", s_addr_o, 32'hD0);
    tick;
    req0(0, 0);
    #2 check("fl_drop_ack", m0_ack_o, 0);
    tick;
    req1(1, 32'hE0); s_ack_i = 1;
    #2 check("fl_late_m0_ack", m0_ack_o, 0);
    check("fl_late_m1_ack", m1_ack_o, 0);
    tick;
    s_ack_i = 0;
    #2 check("fl_next_addr", s_addr_o, 32'hE0);
    tick;
    req1(0, 0);
    tick;
    // reset mid-tenure
    req0(1, 32'hF0);
    tick;
    #2 check("rm_stb", s_stb_o, 1);
    rst = 0; s_ack_i = 1;
    #1 check("rm_s_stb", s_stb_o, 0);
    check("rm_s_cyc", s_cyc_o, 0);
    check("rm_s_addr", s_addr_o, 0);
    check("rm_m0_ack", m0_ack_o, 0);
    tick;
    s_ack_i = 0; rst = 1; req1(1, 32'hF1);
    #2 check("rm_rel_idle", s_stb_o, 0);
    tick;
    #2 check("rm_first_grant", s_addr_o, 32'hF0);
    req0(0, 0); req1(0, 0);
    tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
